regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the RV32 core, replacing the fixed 2-read/1-write file. It provides NRD combinational read ports and NWR write ports with write-to-read forwarding, and an optional hardwired-zero register. A per-register pending scoreboard lets decode stall on outstanding writes. A post-reset clear sequencer zeroes every entry one per cycle, so no initial-value support is needed. The block sits between decode (reads, reservations) and writeback (writes).

## Interface
- XLEN, 32, data width.
- NREGS, 32, number of registers; power of two, at least 2; AW = log2(NREGS).
- NRD, 2, read ports, 1..4.
- NWR, 1, write ports, 1..2.
- ZERO_REG, 1, register 0 reads 0, ignores writes, never pending.
- FWD, 1, same-cycle write data forwarded to reads.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- rf_ready  out  1  high once clearing completes; 0 in reset.
- rd_addr  in  NRD*AW  packed read addresses; port p is slice p.
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_pend  out  NRD  per-port pending flag, combinational.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*XLEN  packed write data.
- rsv_en  in  1  reserve a destination register (mark pending).
- rsv_addr  in  AW  register to reserve.

## Operation
- Two states: CLEAR and READY.
- rst high: state becomes CLEAR, clear counter becomes 0, all pending bits become 0, rf_ready is 0.
- CLEAR, each edge with rst low:
  - Writes 0 to entry [cnt], then increments cnt.
  - After entry NREGS-1 is written, state becomes READY.
  - Writes and reservations are ignored.
  - rd_data is 0 and rd_pend is 0 on every port.
- READY, write:
  - Each port with wr_en high and a legal address (nonzero when ZERO_REG=1) writes its entry.
  - Two ports to the same address: port NWR-1 wins.
  - A write clears the pending bit of its address.
- READY, reserve:
  - rsv_en with a legal address sets that pending bit.
  - Set and clear of the same address in one cycle: set wins.
- READY, read port p:
  - Address 0 with ZERO_REG=1: data 0.
  - Else if FWD=1 and a legal write targets the address: highest-index matching wr_data.
  - Else: stored value.
- rd_pend[p] = pending[addr] AND NOT (FWD=1 and a forwarding hit on that port).
- rst mid-clear restarts at entry 0. rst in READY re-runs the full clear.

## Timing
- Reads are zero-latency, combinational from rd_addr, wr_* and state.
- Writes are visible from storage on the edge after they are presented; with FWD=1 they are also visible in the same cycle.
- rf_ready rises NREGS edges after the first edge with rst low. Example: NREGS=32, rst low before edge 1 gives rf_ready high after edge 32.
- The pending bit updates on the edge; rd_pend reflects a reservation from the cycle after rsv_en.
- No handshake on ports; the consumer must gate on rf_ready.

## Structure
- Shared package rv_pkg holds XLEN_DEF, NREGS_DEF and the state encoding (CLEAR/READY as a 1-bit enum).
- Sub-module regfile_fwd_mux holds the forwarding/zero select for one read port, instantiated NRD times by generate.
- Storage, clear sequencer and scoreboard live in the top level.
- Storage must map to LUTRAM when NWR=1; flops are acceptable when NWR=2.

## Test plan
- Clear: pulse rst 1 cycle (NREGS=32) -> rf_ready 0 for 32 edges then 1; all 32 registers read 0; a write of 0xDEADBEEF to x5 during CLEAR is lost and x5 reads 0.
- Forwarding: in READY, write x7=0x12345678 and read x7 on port 1 in the same cycle -> port 1 returns 0x12345678 with FWD=1, and the old value 0 with FWD=0.
- Zero register: write x0=0xFFFFFFFF, then read x0 -> 0; rsv x0 -> rd_pend 0.
- Dual write collision (NWR=2): port0 x3=0x1, port1 x3=0x2 -> x3 reads 0x2 next cycle, and the same-cycle forward is also 0x2.
- Scoreboard: rsv x9, next cycle read x9 -> rd_pend 1; write x9=0xA5 -> rd_pend 0 and data 0xA5 in that cycle (FWD=1). rsv and write x9 in the same cycle -> rd_pend 1 next cycle.
- Reset mid-clear: assert rst at cnt=10 -> counter restarts, rf_ready high 32 edges after rst drops, pending bits all 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: default widths and the register-file
// sequencer state encoding.
package rv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Read-port select for one port: clear blanking, hardwired zero, same-cycle
// write forwarding (highest write port wins) and pending-flag masking.
module regfile_fwd_mux #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit FWD      = 1'b1
) (
  input  logic                ready,
  input  logic [AW-1:0]       addr,
  input  logic [XLEN-1:0]     mem_data,
  input  logic                pend_bit,
  input  logic [NWR-1:0]      wr_legal,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     rd_data,
  output logic                rd_pend
);

  logic            hit_s;
  logic [XLEN-1:0] fwd_data_s;

  // Forward-hit search; later ports overwrite earlier ones so the top port wins
  always_comb begin
    hit_s      = 1'b0;
    fwd_data_s = {XLEN{1'b0}};
    for (int w = 0; w < NWR; w++) begin
      if (wr_legal[w] && (wr_addr[w*AW +: AW] == addr)) begin
        hit_s      = 1'b1;
        fwd_data_s = wr_data[w*XLEN +: XLEN];
      end else begin
        hit_s      = hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Final data/pending select
  always_comb begin
    rd_data = {XLEN{1'b0}};
    rd_pend = 1'b0;
    if (!ready) begin
      rd_data = {XLEN{1'b0}};
      rd_pend = 1'b0;
    end else if (ZERO_REG && (addr == {AW{1'b0}})) begin
      rd_data = {XLEN{1'b0}};
      rd_pend = 1'b0;
    end else if (FWD && hit_s) begin
      rd_data = fwd_data_s;
      rd_pend = 1'b0;
    end else begin
      rd_data = mem_data;
      rd_pend = pend_bit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with post-reset clear
// sequencer and per-register pending scoreboard.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit FWD      = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rf_ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
);

  rf_state_e       state_r, state_nx_s;
  logic [AW-1:0]   cnt_r, cnt_nx_s;
  logic [XLEN-1:0] mem_r [NREGS];
  logic [NREGS-1:0] pend_r, pend_nx_s;
  logic            ready_s;
  logic            rsv_legal_s;
  logic [NWR-1:0]  wr_legal_s;
  logic [NWR-1:0]  we_s;
  logic [AW-1:0]   wa_s [NWR];
  logic [XLEN-1:0] wd_s [NWR];

  assign ready_s  = (state_r == READY);
  assign rf_ready = ready_s;

  // Clear sequencer next state
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        cnt_nx_s = cnt_r + AW'(1);
        if (cnt_r == AW'(NREGS - 1)) state_nx_s = READY;
        else                          state_nx_s = CLEAR;
      end
      READY:   state_nx_s = READY;
      default: state_nx_s = CLEAR;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      cnt_r   <= {AW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Qualify writes and reservations: only in READY and never to x0
  always_comb begin
    wr_legal_s = {NWR{1'b0}};
    for (int w = 0; w < NWR; w++) begin
      if (ready_s && wr_en[w] && (!ZERO_REG || (wr_addr[w*AW +: AW] != {AW{1'b0}})))
        wr_legal_s[w] = 1'b1;
      else
        wr_legal_s[w] = 1'b0;
    end
    if (ready_s && rsv_en && (!ZERO_REG || (rsv_addr != {AW{1'b0}}))) rsv_legal_s = 1'b1;
    else                                                             rsv_legal_s = 1'b0;
  end

  // The clear write shares port 0 so NWR=1 keeps a single write port (LUTRAM)
  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      we_s[w] = wr_legal_s[w];
      wa_s[w] = wr_addr[w*AW +: AW];
      wd_s[w] = wr_data[w*XLEN +: XLEN];
    end
    if (!ready_s) begin
      we_s[0] = 1'b1;
      wa_s[0] = cnt_r;
      wd_s[0] = {XLEN{1'b0}};
    end else begin
      we_s[0] = we_s[0];
    end
  end

  // Register storage; later ports win on address collision
  always_ff @(posedge clk) begin
    for (int w = 0; w < NWR; w++) begin
      if (we_s[w]) mem_r[wa_s[w]] <= wd_s[w];
    end
  end

  // Scoreboard next state: writes clear, reservation set applied last so it wins
  always_comb begin
    pend_nx_s = pend_r;
    for (int w = 0; w < NWR; w++) begin
      if (wr_legal_s[w]) pend_nx_s[wr_addr[w*AW +: AW]] = 1'b0;
      else               pend_nx_s = pend_nx_s;
    end
    if (rsv_legal_s) pend_nx_s[rsv_addr] = 1'b1;
    else             pend_nx_s = pend_nx_s;
  end

  // Pending register
  always_ff @(posedge clk) begin
    if (rst) pend_r <= {NREGS{1'b0}};
    else     pend_r <= pend_nx_s;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_fwd_mux #(
      .XLEN(XLEN), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG), .FWD(FWD)
    ) u_mux (
      .ready   (ready_s),
      .addr    (rd_addr[p*AW +: AW]),
      .mem_data(mem_r[rd_addr[p*AW +: AW]]),
      .pend_bit(pend_r[rd_addr[p*AW +: AW]]),
      .wr_legal(wr_legal_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p*XLEN +: XLEN]),
      .rd_pend (rd_pend[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: dual-write/forwarding instance (a) and a
// single-write no-forwarding instance (b) sharing write port 0 and reads.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rdy_a, rdy_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_pend_a, rd_pend_b;

  always #5 clk = ~clk;

  regfile_mp #(.NRD(2), .NWR(2), .FWD(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .rf_ready(rdy_a), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_pend(rd_pend_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  regfile_mp #(.NRD(2), .NWR(1), .FWD(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .rf_ready(rdy_b), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_pend(rd_pend_b), .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rsv;
    logic [4:0]  rsva;
    logic [31:0] ad0;
    logic [31:0] ad1;
    logic [1:0]  ap;
    logic [31:0] bd0;
    logic [31:0] bd1;
    logic [1:0]  bp;
  } vec_t;

  exp_t q[$];
  vec_t tbl [12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got=%h", act);
    end else begin
      e = q.pop_front();
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s got=%h exp=%h", e.nm, act, e.v);
      end
    end
  endtask

  task automatic idle_inputs();
    wr_en    = 2'b00;
    wr_addr  = 10'd0;
    wr_data  = 64'd0;
    rsv_en   = 1'b0;
    rsv_addr = 5'd0;
    rd_addr  = 10'd0;
  endtask

  // Count clear edges after rst drops; rf_ready must rise exactly on edge 32
  task automatic clear_count(input string tag);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      push({tag, "_rdy_a"}, {31'd0, (k == 32)});
      push({tag, "_rdy_b"}, {31'd0, (k == 32)});
      pop_chk({31'd0, rdy_a});
      pop_chk({31'd0, rdy_b});
      if (k == 5) begin
        wr_en  = 2'b00;
        rsv_en = 1'b0;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{2'b01, 5'd7, 32'h1234_5678, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0,
                32'd0, 32'h1234_5678, 2'b00, 32'd0, 32'd0, 2'b00};
    tbl[1]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0,
                32'h1234_5678, 32'h1234_5678, 2'b00, 32'h1234_5678, 32'h1234_5678, 2'b00};
    tbl[2]  = '{2'b11, 5'd3, 32'h1, 5'd3, 32'h2, 5'd3, 5'd7, 1'b0, 5'd0,
                32'h2, 32'h1234_5678, 2'b00, 32'd0, 32'h1234_5678, 2'b00};
    tbl[3]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0, 5'd0,
                32'h2, 32'd0, 2'b00, 32'h1, 32'd0, 2'b00};
    tbl[4]  = '{2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0,
                32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00};
    tbl[5]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b1, 5'd9,
                32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00};
    tbl[6]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b0, 5'd0,
                32'd0, 32'd0, 2'b10, 32'd0, 32'd0, 2'b10};
    tbl[7]  = '{2'b01, 5'd9, 32'hA5, 5'd0, 32'd0, 5'd0, 5'd9, 1'b0, 5'd0,
                32'd0, 32'hA5, 2'b00, 32'd0, 32'd0, 2'b10};
    tbl[8]  = '{2'b01, 5'd9, 32'h5A, 5'd0, 32'd0, 5'd0, 5'd9, 1'b1, 5'd9,
                32'd0, 32'h5A, 2'b00, 32'd0, 32'hA5, 2'b00};
    tbl[9]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b0, 5'd0,
                32'd0, 32'h5A, 2'b10, 32'd0, 32'h5A, 2'b10};
    tbl[10] = '{2'b10, 5'd0, 32'd0, 5'd9, 32'h77, 5'd9, 5'd3, 1'b0, 5'd0,
                32'h77, 32'h2, 2'b00, 32'h5A, 32'h1, 2'b01};
    tbl[11] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd3, 1'b0, 5'd0,
                32'h77, 32'h2, 2'b00, 32'h5A, 32'h1, 2'b01};

    // Reset and initial clear, with a write/reservation to x5 that must be dropped
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    push("reset_rdy_a", 32'd0);
    pop_chk({31'd0, rdy_a});
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd5};
    wr_data  = {32'd0, 32'hDEAD_BEEF};
    rsv_en   = 1'b1;
    rsv_addr = 5'd5;
    rd_addr  = {5'd5, 5'd5};
    #2;
    push("clear_rd_blank", 32'd0);
    push("clear_pend_blank", 32'd0);
    pop_chk(rd_data_a[31:0]);
    pop_chk({30'd0, rd_pend_a});
    clear_count("clear");

    // Every register reads zero and is not pending after the clear
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(2*i+1), 5'(2*i)};
      #2;
      push($sformatf("zero_x%0d", 2*i), 32'd0);
      push($sformatf("zero_x%0d", 2*i+1), 32'd0);
      push($sformatf("nopend_x%0d_x%0d", 2*i, 2*i+1), 32'd0);
      pop_chk(rd_data_a[31:0]);
      pop_chk(rd_data_a[63:32]);
      pop_chk({30'd0, rd_pend_a});
      @(negedge clk);
    end

    // Table-driven READY-state vectors; each row is one cycle in order
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      wr_en    = tbl[i].we;
      wr_addr  = {tbl[i].wa1, tbl[i].wa0};
      wr_data  = {tbl[i].wd1, tbl[i].wd0};
      rd_addr  = {tbl[i].ra1, tbl[i].ra0};
      rsv_en   = tbl[i].rsv;
      rsv_addr = tbl[i].rsva;
      push($sformatf("v%0d_a_rd0", i), tbl[i].ad0);
      push($sformatf("v%0d_a_rd1", i), tbl[i].ad1);
      push($sformatf("v%0d_a_pend", i), {30'd0, tbl[i].ap});
      push($sformatf("v%0d_b_rd0", i), tbl[i].bd0);
      push($sformatf("v%0d_b_rd1", i), tbl[i].bd1);
      push($sformatf("v%0d_b_pend", i), {30'd0, tbl[i].bp});
      @(negedge clk);
      pop_chk(rd_data_a[31:0]);
      pop_chk(rd_data_a[63:32]);
      pop_chk({30'd0, rd_pend_a});
      pop_chk(rd_data_b[31:0]);
      pop_chk(rd_data_b[63:32]);
      pop_chk({30'd0, rd_pend_b});
    end

    // Reset from READY, then a second reset at clear count 10
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    push("midclear_rdy_a", 32'd0);
    pop_chk({31'd0, rdy_a});
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_count("reclear");

    // Contents and pending bits are wiped by the re-clear
    rd_addr = {5'd9, 5'd7};
    #2;
    push("reclear_a_x7", 32'd0);
    push("reclear_a_x9", 32'd0);
    push("reclear_b_x9", 32'd0);
    push("reclear_a_pend", 32'd0);
    push("reclear_b_pend", 32'd0);
    pop_chk(rd_data_a[31:0]);
    pop_chk(rd_data_a[63:32]);
    pop_chk(rd_data_b[63:32]);
    pop_chk({30'd0, rd_pend_a});
    pop_chk({30'd0, rd_pend_b});

    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
